// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and default widths for the IF/DM memory port arbiter.
//   arb_state_e : arbiter FSM states
//   grant_e     : which requester owns the memory port
//   DEF_*_WIDTH : default address/data widths used by the interface and the top
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    XFER_IF,
    XFER_DM,
    RESP
  } arb_state_e;

  typedef enum logic {
    GNT_IF,
    GNT_DM
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, the data port and the memory port
// of the arbiter.
//   master modport : the arbiter itself (takes requests, drives done/rdata and mem_*)
//   slave modport  : the environment (core stages driving requests, memory model
//                    driving mem_ack/mem_rdata)
// Signals:
//   if_req/if_addr -> if_rdata/if_done                       fetch port
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata -> dm_rdata/dm_done  data port
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata <- mem_ack/mem_rdata  memory port
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                    if_req;
  logic [ADDR_WIDTH-1:0]   if_addr;
  logic [DATA_WIDTH-1:0]   if_rdata;
  logic                    if_done;

  logic                    dm_req;
  logic                    dm_we;
  logic [DATA_WIDTH/8-1:0] dm_be;
  logic [ADDR_WIDTH-1:0]   dm_addr;
  logic [DATA_WIDTH-1:0]   dm_wdata;
  logic [DATA_WIDTH-1:0]   dm_rdata;
  logic                    dm_done;

  logic                    mem_req;
  logic                    mem_we;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_ack;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    input  if_req, if_addr,
    output if_rdata, if_done,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_rdata, dm_done,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output if_req, if_addr,
    input  if_rdata, if_done,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_rdata, dm_done,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch (IF)
// and data memory (DM). Each access: arbitrate in IDLE, latch fields into mem_*,
// hold mem_req until mem_ack, then one RESP cycle pulsing the granted done.
// All outputs are registered.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (abandons any access in flight)
//   bus  : mem_port_arbiter_if.master (fetch, data and memory ports)
// Build option:
//   ARB_FAIR_EN : when defined, simultaneous requests alternate using a last-grant
//                 bit; otherwise DM always wins over IF.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access open; arbitrate and latch the winner's fields
// XFER_IF | fetch on the memory port, waiting for mem_ack
// XFER_DM | load/store on the memory port, waiting for mem_ack
// RESP    | one-cycle done pulse to the granted requester; no arbitration
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  arb_state_e              state_q, state_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [BE_WIDTH-1:0]     mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]   dm_rdata_q, dm_rdata_d;
  logic                    if_done_q, if_done_d;
  logic                    dm_done_q, dm_done_d;
  grant_e                  gnt;
  logic                    gnt_take;

`ifdef ARB_FAIR_EN
  grant_e                  last_grant_q;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    gnt         = GNT_IF;
    gnt_take    = 1'b0;

    if (bus.dm_req && bus.if_req) begin
`ifdef ARB_FAIR_EN
      gnt = (last_grant_q == GNT_DM) ? GNT_IF : GNT_DM;
`else
      gnt = GNT_DM;
`endif
    end else if (bus.dm_req) begin
      gnt = GNT_DM;
    end

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          gnt_take  = 1'b1;
          mem_req_d = 1'b1;
          if (gnt == GNT_DM) begin
            mem_we_d    = bus.dm_we;
            mem_be_d    = bus.dm_be;
            mem_addr_d  = bus.dm_addr;
            mem_wdata_d = bus.dm_wdata;
            state_d     = XFER_DM;
          end else begin
            // A fetch is a full-word read.
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            state_d     = XFER_IF;
          end
        end
      end
      XFER_IF: begin
        if (bus.mem_ack) begin
          if_rdata_d = bus.mem_rdata;
          if_done_d  = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = RESP;
        end
      end
      XFER_DM: begin
        if (bus.mem_ack) begin
          // Stores leave the last load data visible on dm_rdata.
          if (!mem_we_q) begin
            dm_rdata_d = bus.mem_rdata;
          end
          dm_done_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
    end
  end

`ifdef ARB_FAIR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GNT_IF;
    end else if (gnt_take) begin
      last_grant_q <= gnt;
    end
  end
`endif

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_done   = dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter.
// A single process drives requests, plays the memory model and monitors outputs
// through tick(). Expected responses and expected memory-port fields are queued
// when stimulus is driven and popped when the DUT produces them.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        is_dm;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } fields_t;

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] exp_rdata;
  } vec_t;

  resp_t   resp_q[$];
  fields_t fld_q[$];
  fields_t cur_fld;
  vec_t    vecs[6];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mem_wait = 0;
  int wait_cnt = 0;
  int inject_n = 0;
  int last_done_cyc = 0;
  int if_done_cyc = 0;
  int dm_done_cyc = 0;
  bit mem_auto = 1'b1;
  bit keep_if = 1'b0;
  bit keep_dm = 1'b0;
  bit prev_mem_req = 1'b0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h00A0_0093;
      32'h0000_0100: return 32'hDEAD_BEEF;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    resp_t r;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.mem_ack) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      wait_cnt      = 0;
    end else if (inject_n > 0) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hBAD0_0BAD;
      inject_n--;
    end else if (bus.mem_req && mem_auto) begin
      if (wait_cnt >= mem_wait) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_model(bus.mem_addr);
      end else begin
        wait_cnt++;
        bus.mem_rdata = $urandom;
      end
    end else begin
      wait_cnt      = 0;
      bus.mem_rdata = $urandom;
    end

    @(negedge clk);
    if (bus.mem_req && !prev_mem_req) begin
      if (fld_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mem_req_unexpected: got mem_req=1 addr=%0h required no request", bus.mem_addr);
      end else begin
        cur_fld = fld_q.pop_front();
      end
    end
    if (bus.mem_req) begin
      check("mem_fields", 128'({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}),
            128'({cur_fld.we, cur_fld.be, cur_fld.addr, cur_fld.wdata}));
    end
    prev_mem_req = bus.mem_req;

    if (bus.if_done || bus.dm_done) begin
      last_done_cyc = cyc;
      if (bus.if_done) if_done_cyc = cyc;
      if (bus.dm_done) dm_done_cyc = cyc;
      if (resp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: got if_done=%0b dm_done=%0b required none", bus.if_done, bus.dm_done);
      end else begin
        r = resp_q.pop_front();
        check("done_kind", 128'({bus.if_done, bus.dm_done}), 128'({~r.is_dm, r.is_dm}));
        if (r.is_dm) check("dm_rdata", 128'(bus.dm_rdata), 128'(r.rdata));
        else         check("if_rdata", 128'(bus.if_rdata), 128'(r.rdata));
      end
      if (bus.if_done && !keep_if) bus.if_req = 1'b0;
      if (bus.dm_done && !keep_dm) bus.dm_req = 1'b0;
    end
  endtask

  task automatic exp_if(input logic [31:0] addr, input logic [31:0] rdata);
    fields_t f;
    resp_t   r;
    f = '{we: 1'b0, be: 4'hF, addr: addr, wdata: 32'h0};
    r = '{is_dm: 1'b0, rdata: rdata};
    fld_q.push_back(f);
    resp_q.push_back(r);
  endtask

  task automatic exp_dm(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata);
    fields_t f;
    resp_t   r;
    f = '{we: we, be: be, addr: addr, wdata: wdata};
    r = '{is_dm: 1'b1, rdata: rdata};
    fld_q.push_back(f);
    resp_q.push_back(r);
  endtask

  task automatic req_if(input logic [31:0] addr);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
  endtask

  task automatic req_dm(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata);
    bus.dm_req   = 1'b1;
    bus.dm_we    = we;
    bus.dm_be    = be;
    bus.dm_addr  = addr;
    bus.dm_wdata = wdata;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (resp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (resp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: timeout with %0d responses pending, required 0", name, resp_q.size());
      resp_q.delete();
      fld_q.delete();
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
    end
  endtask

  initial begin
    vec_t v;
    int   start;
    int   n;
    int   guard;
    bit   ord[4];

    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_be     = '0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    vecs[0] = '{is_dm: 1'b0, we: 1'b0, be: 4'h0, addr: 32'h0000_0010, wdata: 32'h0,
                waits: 0, exp_rdata: 32'h00A0_0093};
    vecs[1] = '{is_dm: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h0000_0100, wdata: 32'h0,
                waits: 0, exp_rdata: 32'hDEAD_BEEF};
    vecs[2] = '{is_dm: 1'b1, we: 1'b1, be: 4'b0011, addr: 32'h0000_0200, wdata: 32'h1234_5678,
                waits: 3, exp_rdata: 32'hDEAD_BEEF};
    vecs[3] = '{is_dm: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h0000_0020, wdata: 32'h0,
                waits: 1, exp_rdata: 32'h0020_FFDF};
    vecs[4] = '{is_dm: 1'b1, we: 1'b1, be: 4'b1100, addr: 32'h0000_0300, wdata: 32'hCAFE_F00D,
                waits: 0, exp_rdata: 32'h0020_FFDF};
    vecs[5] = '{is_dm: 1'b0, we: 1'b0, be: 4'h0, addr: 32'h0000_0404, wdata: 32'h0,
                waits: 2, exp_rdata: 32'h0404_FBFB};

    repeat (3) tick();
    check("rst_ctrl", 128'({bus.mem_req, bus.mem_we, bus.if_done, bus.dm_done}), 128'(0));
    check("rst_mem_fields", 128'({bus.mem_be, bus.mem_addr, bus.mem_wdata}), 128'(0));
    check("rst_rdata", 128'({bus.if_rdata, bus.dm_rdata}), 128'(0));
    rst = 1'b0;
    tick();

    // Single-requester accesses, including the store with three wait cycles.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      mem_wait = v.waits;
      if (v.is_dm) begin
        exp_dm(v.we, v.be, v.addr, v.wdata, v.exp_rdata);
        req_dm(v.we, v.be, v.addr, v.wdata);
      end else begin
        exp_if(v.addr, v.exp_rdata);
        req_if(v.addr);
      end
      start = cyc;
      wait_drain($sformatf("vec%0d_drain", i), 40);
      check($sformatf("vec%0d_latency", i), 128'(last_done_cyc - start), 128'(2 + v.waits));
      tick();
    end
    mem_wait = 0;

    // Both requesters in the same IDLE cycle: DM first, IF three cycles later.
    exp_dm(1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
    exp_if(32'h0000_0040, 32'h0040_FFBF);
    req_dm(1'b0, 4'hF, 32'h0000_0100, 32'h0);
    req_if(32'h0000_0040);
    wait_drain("both_drain", 40);
    check("both_gap", 128'(if_done_cyc - dm_done_cyc), 128'(3));
    tick();

    // Reset in the middle of a fetch, then a stray ack, then a clean fetch.
    mem_auto = 1'b0;
    begin
      fields_t f;
      f = '{we: 1'b0, be: 4'hF, addr: 32'h0000_0080, wdata: 32'h0};
      fld_q.push_back(f);
    end
    req_if(32'h0000_0080);
    tick();
    tick();
    check("rst_mid_req_before", 128'(bus.mem_req), 128'(1));
    rst = 1'b1;
    tick();
    check("rst_mid_req_after", 128'(bus.mem_req), 128'(0));
    check("rst_mid_no_done", 128'({bus.if_done, bus.dm_done}), 128'(0));
    bus.if_req = 1'b0;
    rst = 1'b0;
    inject_n = 1;
    repeat (4) begin
      tick();
      check("stray_ack_no_done", 128'({bus.if_done, bus.dm_done, bus.mem_req}), 128'(0));
    end
    mem_auto = 1'b1;
    exp_if(32'h0000_0080, 32'h0080_FF7F);
    req_if(32'h0000_0080);
    start = cyc;
    wait_drain("after_rst_drain", 40);
    check("after_rst_latency", 128'(last_done_cyc - start), 128'(2));
    tick();

    // Ack while idle, and IF toggling its request while DM holds the port.
    inject_n = 1;
    repeat (2) begin
      tick();
      check("idle_ack_no_done", 128'({bus.if_done, bus.dm_done, bus.mem_req}), 128'(0));
    end
    mem_wait = 2;
    exp_dm(1'b0, 4'hF, 32'h0000_0600, 32'h0, 32'h0600_F9FF);
    exp_if(32'h0000_0508, 32'h0508_FAF7);
    req_dm(1'b0, 4'hF, 32'h0000_0600, 32'h0);
    tick();
    req_if(32'h0000_0500);
    tick();
    bus.if_req = 1'b0;
    tick();
    req_if(32'h0000_0504);
    tick();
    bus.if_addr = 32'h0000_0508;
    wait_drain("toggle_drain", 40);
    mem_wait = 0;
    tick();

    // Continuous requests from both sides for four grants, after a DM-only access.
    exp_dm(1'b0, 4'hF, 32'h0000_0704, 32'h0, 32'h0704_F8FB);
    req_dm(1'b0, 4'hF, 32'h0000_0704, 32'h0);
    wait_drain("stream_pre_drain", 40);
    tick();
`ifdef ARB_FAIR_EN
    ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    ord = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int k = 0; k < 4; k++) begin
      if (ord[k]) exp_dm(1'b0, 4'hF, 32'h0000_0704, 32'h0, 32'h0704_F8FB);
      else        exp_if(32'h0000_0700, 32'h0700_F8FF);
    end
    keep_if = 1'b1;
    keep_dm = 1'b1;
    req_if(32'h0000_0700);
    req_dm(1'b0, 4'hF, 32'h0000_0704, 32'h0);
    n = 0;
    guard = 0;
    while (n < 4 && guard < 60) begin
      tick();
      guard++;
      if (bus.if_done || bus.dm_done) n++;
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    keep_if = 1'b0;
    keep_dm = 1'b0;
    check("stream_grants", 128'(n), 128'(4));
    wait_drain("stream_drain", 5);
    repeat (4) begin
      tick();
      check("stream_quiet", 128'({bus.if_done, bus.dm_done}), 128'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
